// File: rtl/regfile_scoreboard.sv
// Register file with three combinational read ports, two write ports and a
// busy scoreboard for multi-cycle producers, plus hazard and sticky error status.
module regfile_scoreboard #(
    parameter int WIDTH         = 32,
    parameter int LOG2_NUM_REGS = 4,
    parameter int PC_REG        = 15,
    parameter bit BYPASS        = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [LOG2_NUM_REGS-1:0]           ra1,
    input  logic [LOG2_NUM_REGS-1:0]           ra2,
    input  logic [LOG2_NUM_REGS-1:0]           ra3,
    input  logic [2:0]                         ren,
    output logic [WIDTH-1:0]                   rd1,
    output logic [WIDTH-1:0]                   rd2,
    output logic [WIDTH-1:0]                   rd3,
    input  logic [WIDTH-1:0]                   r15_in,
    input  logic                               we_a,
    input  logic [LOG2_NUM_REGS-1:0]           wa_a,
    input  logic [WIDTH-1:0]                   wd_a,
    input  logic                               we_b,
    input  logic [LOG2_NUM_REGS-1:0]           wa_b,
    input  logic [WIDTH-1:0]                   wd_b,
    input  logic                               issue_valid,
    input  logic [LOG2_NUM_REGS-1:0]           issue_dst,
    output logic                               hazard,
    output logic [(2**LOG2_NUM_REGS)-1:0]      busy,
    output logic [LOG2_NUM_REGS:0]             pending_cnt,
    output logic [2:0]                         err,
    input  logic                               err_clr,
    output logic [(2**LOG2_NUM_REGS)*WIDTH-1:0] debug_regs
);
    localparam int NUM_REGS = 2**LOG2_NUM_REGS;
    localparam logic [LOG2_NUM_REGS-1:0] PC_IDX = LOG2_NUM_REGS'(PC_REG);

    logic [NUM_REGS-1:0][WIDTH-1:0]   regs;
    logic [2:0][LOG2_NUM_REGS-1:0]    ra;
    logic [2:0][WIDTH-1:0]            rd;
    logic [NUM_REGS-1:0]              busy_nxt;
    logic [LOG2_NUM_REGS:0]           cnt_nxt;
    logic [2:0]                       err_new;
    logic                             retire_dst;

    assign ra         = {ra3, ra2, ra1};
    assign rd1        = rd[0];
    assign rd2        = rd[1];
    assign rd3        = rd[2];
    assign debug_regs = regs;
    assign retire_dst = we_b && (wa_b == issue_dst);

    // Port B forwards ahead of port A, matching port B winning the write.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            if (ra[k] == PC_IDX)
                rd[k] = r15_in;
            else if (BYPASS && we_b && wa_b == ra[k])
                rd[k] = wd_b;
            else if (BYPASS && we_a && wa_a == ra[k])
                rd[k] = wd_a;
            else
                rd[k] = regs[ra[k]];
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (ren[k] && ra[k] != PC_IDX && busy[ra[k]] &&
                !(BYPASS && we_b && wa_b == ra[k]))
                hazard = 1'b1;
        end
        if (issue_valid && issue_dst != PC_IDX && busy[issue_dst] && !retire_dst)
            hazard = 1'b1;
    end

    // A new issue supersedes a same-cycle retire of the same register.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == PC_REG)
                busy_nxt[i] = 1'b0;
            else if (issue_valid && issue_dst == LOG2_NUM_REGS'(i))
                busy_nxt[i] = 1'b1;
            else if (we_b && wa_b == LOG2_NUM_REGS'(i))
                busy_nxt[i] = 1'b0;
            cnt_nxt = cnt_nxt + {{LOG2_NUM_REGS{1'b0}}, busy_nxt[i]};
        end
    end

    // WAW only flags issues that decode would have stalled on: a same-cycle
    // retire of the destination makes the re-issue legal.
    always_comb begin
        err_new    = 3'b000;
        err_new[0] = we_a && we_b && (wa_a == wa_b);
        err_new[1] = we_b && (wa_b != PC_IDX) && !busy[wa_b];
        err_new[2] = issue_valid && (issue_dst != PC_IDX) && busy[issue_dst] && !retire_dst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs        <= '0;
            busy        <= '0;
            pending_cnt <= '0;
            err         <= '0;
        end else begin
            if (we_a && wa_a != PC_IDX)
                regs[wa_a] <= wd_a;
            if (we_b && wa_b != PC_IDX)
                regs[wa_b] <= wd_b;
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
            err         <= (err & {3{~err_clr}}) | err_new;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, reset corner cases and
// a randomized run against an array-based reference model.
module tb_regfile_scoreboard;
    localparam int W  = 32;
    localparam int L  = 4;
    localparam int N  = 16;
    localparam int PC = 15;

    logic clk = 1'b0;
    logic rst;
    logic [L-1:0] ra1, ra2, ra3, wa_a, wa_b, issue_dst;
    logic [2:0] ren, err, err_nb;
    logic [W-1:0] rd1, rd2, rd3, rd1_nb, rd2_nb, rd3_nb, r15_in, wd_a, wd_b;
    logic we_a, we_b, issue_valid, err_clr, hazard, hazard_nb;
    logic [N-1:0] busy, busy_nb;
    logic [L:0] pending_cnt, cnt_nb;
    logic [N*W-1:0] debug_regs, dbg_nb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.WIDTH(W), .LOG2_NUM_REGS(L), .PC_REG(PC), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .ra3(ra3), .ren(ren),
        .rd1(rd1), .rd2(rd2), .rd3(rd3), .r15_in(r15_in),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .hazard(hazard), .busy(busy),
        .pending_cnt(pending_cnt), .err(err), .err_clr(err_clr), .debug_regs(debug_regs));

    regfile_scoreboard #(.WIDTH(W), .LOG2_NUM_REGS(L), .PC_REG(PC), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .ra3(ra3), .ren(ren),
        .rd1(rd1_nb), .rd2(rd2_nb), .rd3(rd3_nb), .r15_in(r15_in),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .hazard(hazard_nb), .busy(busy_nb),
        .pending_cnt(cnt_nb), .err(err_nb), .err_clr(err_clr), .debug_regs(dbg_nb));

    // ---------------- reference model ----------------
    logic [W-1:0] mregs [N];
    bit           mbusy [N];
    logic [2:0]   merr;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
        merr = '0;
    endtask

    function automatic logic [W-1:0] mread(input logic [L-1:0] a, input bit byp);
        if (int'(a) == PC) return r15_in;
        if (byp && we_b && wa_b == a) return wd_b;
        if (byp && we_a && wa_a == a) return wd_a;
        return mregs[a];
    endfunction

    function automatic bit mhaz();
        logic [L-1:0] a;
        bit h = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = (k == 0) ? ra1 : (k == 1) ? ra2 : ra3;
            if (ren[k] && int'(a) != PC && mbusy[a] && !(we_b && wa_b == a)) h = 1'b1;
        end
        if (issue_valid && int'(issue_dst) != PC && mbusy[issue_dst] &&
            !(we_b && wa_b == issue_dst)) h = 1'b1;
        return h;
    endfunction

    task automatic model_commit();
        logic [2:0] e;
        e[0] = we_a && we_b && wa_a == wa_b;
        e[1] = we_b && int'(wa_b) != PC && !mbusy[wa_b];
        e[2] = issue_valid && int'(issue_dst) != PC && mbusy[issue_dst] &&
               !(we_b && wa_b == issue_dst);
        if (we_a && int'(wa_a) != PC) mregs[wa_a] = wd_a;
        if (we_b && int'(wa_b) != PC) mregs[wa_b] = wd_b;
        if (we_b && int'(wa_b) != PC) mbusy[wa_b] = 1'b0;
        if (issue_valid && int'(issue_dst) != PC) mbusy[issue_dst] = 1'b1;
        merr = err_clr ? e : (merr | e);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        ra1 = '0; ra2 = '0; ra3 = '0; ren = '0;
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        issue_valid = 1'b0; issue_dst = '0; err_clr = 1'b0;
    endtask

    // One model-checked cycle: inputs already driven after a negedge.
    task automatic step();
        logic [N-1:0] eb;
        logic [L:0] ec;
        logic [N*W-1:0] ed;
        #1;
        chk("rd1", rd1, mread(ra1, 1'b1));
        chk("rd2", rd2, mread(ra2, 1'b1));
        chk("rd3", rd3, mread(ra3, 1'b1));
        chk("rd1_nobypass", rd1_nb, mread(ra1, 1'b0));
        chk("rd3_nobypass", rd3_nb, mread(ra3, 1'b0));
        chk("hazard", hazard, mhaz());
        @(posedge clk);
        model_commit();
        #1;
        ec = '0;
        for (int i = 0; i < N; i++) begin
            eb[i] = mbusy[i];
            ec += (L+1)'(mbusy[i]);
            ed[i*W +: W] = mregs[i];
        end
        chk("busy", busy, eb);
        chk("pending_cnt", pending_cnt, ec);
        chk("err", err, merr);
        chk_wide("debug_regs", debug_regs, ed);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         we_a; logic [L-1:0] wa_a; logic [W-1:0] wd_a;
        bit         we_b; logic [L-1:0] wa_b; logic [W-1:0] wd_b;
        bit         iv;   logic [L-1:0] idst; logic [2:0] ren; logic [L-1:0] ra1; bit clr;
        logic [W-1:0] e_rd1; logic [W-1:0] e_rd1_nb; bit e_haz;
        logic [N-1:0] e_busy; logic [L:0] e_cnt; logic [2:0] e_err;
    } vec_t;

    vec_t tv [11];

    initial begin
        tv[0]  = '{1, 3, 'hDEADBEEF, 0, 0, 0,     0, 0, 0, 3, 0, 'hDEADBEEF, 0,          0, 0,       0, 0};
        tv[1]  = '{0, 0, 0,          0, 0, 0,     0, 0, 0, 3, 0, 'hDEADBEEF, 'hDEADBEEF, 0, 0,       0, 0};
        tv[2]  = '{1, 5, 'h11,       1, 5, 'h22,  0, 0, 0, 5, 0, 'h22,       0,          0, 0,       0, 3};
        tv[3]  = '{0, 0, 0,          0, 0, 0,     0, 0, 0, 5, 1, 'h22,       'h22,       0, 0,       0, 0};
        tv[4]  = '{0, 0, 0,          0, 0, 0,     1, 7, 1, 7, 0, 0,          0,          0, 'h0080,  1, 0};
        tv[5]  = '{0, 0, 0,          0, 0, 0,     0, 0, 1, 7, 0, 0,          0,          1, 'h0080,  1, 0};
        tv[6]  = '{0, 0, 0,          1, 7, 'h55,  0, 0, 1, 7, 0, 'h55,       0,          0, 0,       0, 0};
        tv[7]  = '{0, 0, 0,          0, 0, 0,     1, 2, 0, 0, 0, 0,          0,          0, 'h0004,  1, 0};
        tv[8]  = '{0, 0, 0,          1, 2, 'h66,  1, 2, 1, 2, 0, 'h66,       0,          0, 'h0004,  1, 0};
        tv[9]  = '{0, 0, 0,          0, 0, 0,     1, 2, 0, 2, 0, 'h66,       'h66,       1, 'h0004,  1, 4};
        tv[10] = '{0, 0, 0,          1, 9, 'h77,  0, 0, 0, 0, 1, 0,          0,          0, 'h0004,  1, 2};

        idle();
        r15_in = 32'h0000_1008;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_busy", busy, '0);
        chk("rst_cnt", pending_cnt, '0);
        chk("rst_err", err, '0);
        chk_wide("rst_regs", debug_regs, '0);
        for (int a = 0; a < PC; a++) begin
            ra1 = L'(a); ra2 = L'(a); ra3 = L'(a);
            #1;
            chk("rst_read", {rd1, rd2, rd3}, '0);
        end
        ra1 = L'(PC); ra2 = L'(PC); ra3 = L'(PC);
        #1;
        chk("pc_rd1", rd1, 32'h0000_1008);
        chk("pc_rd2", rd2, 32'h0000_1008);
        chk("pc_rd3", rd3, 32'h0000_1008);
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            idle();
            we_a = tv[i].we_a; wa_a = tv[i].wa_a; wd_a = tv[i].wd_a;
            we_b = tv[i].we_b; wa_b = tv[i].wa_b; wd_b = tv[i].wd_b;
            issue_valid = tv[i].iv; issue_dst = tv[i].idst;
            ren = tv[i].ren; ra1 = tv[i].ra1; err_clr = tv[i].clr;
            #1;
            chk($sformatf("v%0d_rd1", i), rd1, tv[i].e_rd1);
            chk($sformatf("v%0d_rd1_nobypass", i), rd1_nb, tv[i].e_rd1_nb);
            chk($sformatf("v%0d_hazard", i), hazard, tv[i].e_haz);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy", i), busy, tv[i].e_busy);
            chk($sformatf("v%0d_cnt", i), pending_cnt, tv[i].e_cnt);
            chk($sformatf("v%0d_err", i), err, tv[i].e_err);
            @(negedge clk);
        end
        idle();
        ra1 = 4'd5; #1;
        chk("r5_port_b_won", rd1_nb, 32'h22);

        // Fill three busy bits, then reset asynchronously mid-cycle.
        err_clr = 1'b1; we_b = 1'b1; wa_b = 4'd2; wd_b = 32'h88;
        @(negedge clk);
        idle(); issue_valid = 1'b1; issue_dst = 4'd1; @(negedge clk);
        issue_dst = 4'd4; @(negedge clk);
        issue_dst = 4'd6; @(negedge clk);
        idle(); #1;
        chk("pre_rst_busy", busy, 16'h0052);
        chk("pre_rst_cnt", pending_cnt, 5'd3);
        chk("pre_rst_err", err, 3'b000);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, '0);
        chk("async_rst_cnt", pending_cnt, '0);
        chk("async_rst_err", err, '0);
        chk_wide("async_rst_regs", debug_regs, '0);
        ra1 = L'(PC); ra2 = 4'd3; r15_in = 32'hCAFE_0004;
        #1;
        chk("rst_pc_read", rd1, 32'hCAFE_0004);
        chk("rst_r3_read", rd2, '0);
        @(negedge clk);
        rst = 1'b0;

        // randomized run against the model
        model_reset();
        for (int c = 0; c < 600; c++) begin
            ra1 = L'($urandom); ra2 = L'($urandom); ra3 = L'($urandom);
            ren = 3'($urandom);
            r15_in = $urandom;
            we_a = ($urandom_range(0, 1) == 1); wa_a = L'($urandom); wd_a = $urandom;
            we_b = ($urandom_range(0, 2) == 0); wa_b = L'($urandom); wd_b = $urandom;
            issue_valid = ($urandom_range(0, 3) == 0); issue_dst = L'($urandom);
            err_clr = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
